// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch front end: word type, fetch FSM states and the
// NOP word presented on instr whenever no valid instruction is held.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t NOP_INSTR = 32'h0;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, reads the icache, presents fetched words to ID.
// Hit-to-instr latency is one cycle; a hit under stall parks in a one-entry buffer until stall drops.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] npc,
  output logic        halted
);

  fetch_state_t state;
  word_t        pc;
  word_t        hold_instr;
  word_t        hold_npc;
  word_t        pc_plus4;

  assign pc_plus4 = pc + 32'd4;
  assign imemREN  = (state == FETCH);
  assign imemaddr = pc;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= FETCH;
      pc          <= PC_INIT;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      npc         <= 32'h0;
      halted      <= 1'b0;
      hold_instr  <= NOP_INSTR;
      hold_npc    <= 32'h0;
    end else if (halt) begin
      // Halt outranks everything, including a redirect in the same cycle.
      state       <= HALTED;
      halted      <= 1'b1;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      hold_instr  <= NOP_INSTR;
      hold_npc    <= 32'h0;
    end else if (state != HALTED) begin
      if (redirect_en) begin
        // Any hit this cycle belongs to the wrong path and is dropped.
        state       <= FETCH;
        pc          <= redirect_pc & 32'hFFFF_FFFC;
        instr       <= NOP_INSTR;
        instr_valid <= 1'b0;
        hold_instr  <= NOP_INSTR;
        hold_npc    <= 32'h0;
      end else if (state == HOLD) begin
        if (!stall) begin
          state       <= FETCH;
          instr       <= hold_instr;
          npc         <= hold_npc;
          instr_valid <= 1'b1;
          hold_instr  <= NOP_INSTR;
          hold_npc    <= 32'h0;
        end
      end else if (ihit) begin
        pc <= pc_plus4;
        if (stall) begin
          state      <= HOLD;
          hold_instr <= iload;
          hold_npc   <= pc_plus4;
        end else begin
          instr       <= iload;
          npc         <= pc_plus4;
          instr_valid <= 1'b1;
        end
      end else if (!stall) begin
        instr       <= NOP_INSTR;
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Two fetch units (PC_INIT 0 and FFFFFFF8) share stimulus; each is compared every cycle
// against a word-level model of the fetch rules, plus directed spot checks.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0;
  logic [31:0] iload = 32'h0;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;

  logic        imemREN0, imemREN1, instr_valid0, instr_valid1, halted0, halted1;
  logic [31:0] imemaddr0, imemaddr1, instr0, instr1, npc0, npc1;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  fetch_unit #(.PC_INIT(32'h0000_0000)) dut0 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload),
    .imemREN(imemREN0), .imemaddr(imemaddr0), .stall(stall),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .halt(halt),
    .instr(instr0), .instr_valid(instr_valid0), .npc(npc0), .halted(halted0)
  );

  fetch_unit #(.PC_INIT(32'hFFFF_FFF8)) dut1 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload),
    .imemREN(imemREN1), .imemaddr(imemaddr1), .stall(stall),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .halt(halt),
    .instr(instr1), .instr_valid(instr_valid1), .npc(npc1), .halted(halted1)
  );

  // Reference model: PC, word offered to ID, and at most one word parked for a stalled ID.
  word_t m_pc[2];
  word_t m_instr[2];
  bit    m_valid[2];
  word_t m_npc[2];
  bit    m_halted[2];
  bit    m_parked[2];
  word_t m_park_w[2];
  word_t m_park_npc[2];

  function automatic word_t init_of(input int i);
    return (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
  endfunction

  function automatic word_t tag(input word_t a);
    return a ^ 32'hC0DE_0001;
  endfunction

  task automatic check(input string name, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = init_of(i);
      m_instr[i] = 32'h0;
      m_valid[i] = 1'b0;
      m_npc[i] = 32'h0;
      m_halted[i] = 1'b0;
      m_parked[i] = 1'b0;
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      if (halt) begin
        m_halted[i] = 1'b1;
        m_instr[i] = 32'h0;
        m_valid[i] = 1'b0;
        m_parked[i] = 1'b0;
      end else if (m_halted[i]) begin
        // frozen until reset
      end else if (redirect_en) begin
        m_pc[i] = {redirect_pc[31:2], 2'b00};
        m_instr[i] = 32'h0;
        m_valid[i] = 1'b0;
        m_parked[i] = 1'b0;
      end else if (m_parked[i]) begin
        if (!stall) begin
          m_instr[i] = m_park_w[i];
          m_npc[i] = m_park_npc[i];
          m_valid[i] = 1'b1;
          m_parked[i] = 1'b0;
        end
      end else if (ihit) begin
        if (stall) begin
          m_parked[i] = 1'b1;
          m_park_w[i] = iload;
          m_park_npc[i] = m_pc[i] + 32'd4;
        end else begin
          m_instr[i] = iload;
          m_npc[i] = m_pc[i] + 32'd4;
          m_valid[i] = 1'b1;
        end
        m_pc[i] = m_pc[i] + 32'd4;
      end else if (!stall) begin
        m_instr[i] = 32'h0;
        m_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    check("ren0",    {31'h0, imemREN0},     {31'h0, !m_halted[0] && !m_parked[0]});
    check("addr0",   imemaddr0,             m_pc[0]);
    check("instr0",  instr0,                m_instr[0]);
    check("valid0",  {31'h0, instr_valid0}, {31'h0, m_valid[0]});
    check("npc0",    npc0,                  m_npc[0]);
    check("halted0", {31'h0, halted0},      {31'h0, m_halted[0]});
    check("ren1",    {31'h0, imemREN1},     {31'h0, !m_halted[1] && !m_parked[1]});
    check("addr1",   imemaddr1,             m_pc[1]);
    check("instr1",  instr1,                m_instr[1]);
    check("valid1",  {31'h0, instr_valid1}, {31'h0, m_valid[1]});
    check("npc1",    npc1,                  m_npc[1]);
    check("halted1", {31'h0, halted1},      {31'h0, m_halted[1]});
  endtask

  task automatic step(input logic h, input word_t ld, input logic st,
                      input logic re, input word_t rp, input logic ha);
    @(negedge CLK);
    ihit = h; iload = ld; stall = st; redirect_en = re; redirect_pc = rp; halt = ha;
    #1;
    compare_all();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    ihit = 1'b0; iload = 32'h0; stall = 1'b0;
    redirect_en = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge CLK);
    #2;
    nRST = 1'b1;
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic hit0();
    step(1'b1, tag(m_pc[0]), 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    int halt_age;
    halt_age = 0;

    // Reset and streaming hits; dut1 wraps through 0.
    do_reset();
    check("rst_addr1", imemaddr1, 32'hFFFF_FFF8);
    hit0();
    hit0();
    check("wrap_addr1", imemaddr1, 32'h0000_0000);
    hit0();
    check("t1_npc", npc0, 32'h0000_000C);
    check("t1_instr", instr0, tag(32'h8));
    hit0();

    // Three-cycle miss at 0x10, then the hit.
    for (int k = 0; k < 3; k++) step(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0);
    check("t2_bubble", {31'h0, instr_valid0}, 32'h0);
    hit0();
    check("t2_npc", npc0, 32'h0000_0014);
    check("t2_instr", instr0, tag(32'h10));

    // Hit under stall at 0x20 parks the word until stall drops.
    hit0(); hit0(); hit0();
    step(1'b1, tag(32'h20), 1'b1, 1'b0, 32'h0, 1'b0);
    check("t3_ren", {31'h0, imemREN0}, 32'h0);
    check("t3_frozen", instr0, tag(32'h1C));
    step(1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("t3_instr", instr0, tag(32'h20));
    check("t3_npc", npc0, 32'h0000_0024);
    check("t3_addr", imemaddr0, 32'h0000_0024);

    // Redirect wins over a parked word, a hit and stall.
    step(1'b1, tag(32'h24), 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 32'hBAD0_BAD0, 1'b1, 1'b1, 32'h0000_0103, 1'b0);
    check("t4_addr", imemaddr0, 32'h0000_0100);
    check("t4_valid", {31'h0, instr_valid0}, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("t4_ren", {31'h0, imemREN0}, 32'h1);

    // Halt beats redirect; frozen for 10 cycles; reset recovers.
    step(1'b1, 32'h5555_AAAA, 1'b0, 1'b1, 32'h0000_0200, 1'b1);
    for (int k = 0; k < 10; k++)
      step($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, 1'b0);
    check("t5_halted", {31'h0, halted0}, 32'h1);
    check("t5_pc", imemaddr0, 32'h0000_0100);
    check("t5_ren", {31'h0, imemREN0}, 32'h0);
    do_reset();
    check("t5_rst_addr", imemaddr0, 32'h0000_0000);
    check("t5_rst_halted", {31'h0, halted0}, 32'h0);

    // Reset asserted while a word is parked.
    hit0();
    step(1'b1, 32'h7777_0000, 1'b1, 1'b0, 32'h0, 1'b0);
    do_reset();

    // Randomized traffic with occasional halt followed by reset.
    for (int n = 0; n < 3000; n++) begin
      if (m_halted[0]) begin
        halt_age++;
        if (halt_age > 4) begin
          do_reset();
          halt_age = 0;
        end
      end
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0,
           $urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 299) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
